// File: rtl/writeback_queue.sv
// Write-back queue: buffers ALU/load results onto the single register-file write port and keeps
// a per-register pending scoreboard. Define WB_BYPASS_EN to let an entry skip an empty queue.
module writeback_queue #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_rd,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  input  logic                       wb_stall,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_rd,
  output logic                       reg_write,
  output logic [ADDR_W-1:0]          RW,
  output logic [DATA_W-1:0]          Bus_W,
  output logic [NUM_REGS-1:0]        pending,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [ADDR_W-1:0]   rd_mem   [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;

  logic                push_acc;
  logic                push_en;
  logic                pop_en;
  logic                byp_en;
  logic                in_range;
  logic [ADDR_W-1:0]   in_rd;
  logic [DATA_W-1:0]   in_data;
  logic [ADDR_W-1:0]   head_rd;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign head_rd   = rd_mem[rd_ptr];

  always_comb begin
    push_acc = (mem_valid || alu_valid) && !full;
    in_rd    = mem_valid ? mem_rd : alu_rd;
    in_data  = mem_valid ? mem_data : alu_data;
    // Out-of-range destinations finish the handshake but are discarded.
    in_range = (in_rd != '0) && (32'(in_rd) < NUM_REGS);
    pop_en   = !empty && !wb_stall;
`ifdef WB_BYPASS_EN
    // Only an already-empty queue is skipped; otherwise the popped head owns the port this edge.
    byp_en   = push_acc && in_range && empty && !wb_stall;
`else
    byp_en   = 1'b0;
`endif
    push_en  = push_acc && in_range && !byp_en;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (issue_valid && (32'(issue_rd) == i)) set_vec[i] = 1'b1;
      if (pop_en && (32'(head_rd) == i))       clr_vec[i] = 1'b1;
      if (byp_en && (32'(in_rd) == i))         clr_vec[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      data_mem[wr_ptr] <= in_data;
      rd_mem[wr_ptr]   <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= '0;
      reg_write <= 1'b0;
      RW        <= '0;
      Bus_W     <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count + CW'(push_en) - CW'(pop_en);
      // Set is applied after clear so a same-edge reissue keeps the bit.
      pending <= (pending & ~clr_vec) | set_vec;
      if (pop_en) begin
        reg_write <= 1'b1;
        RW        <= head_rd;
        Bus_W     <= data_mem[rd_ptr];
      end else if (byp_en) begin
        reg_write <= 1'b1;
        RW        <= in_rd;
        Bus_W     <= in_data;
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_queue;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready;
  logic              mem_valid = 1'b0;
  logic [ADDR_W-1:0] mem_rd = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_ready;
  logic              wb_stall = 1'b0;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic              reg_write;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] Bus_W;
  logic [NUM_REGS-1:0] pending;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  writeback_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .reg_write(reg_write), .RW(RW), .Bus_W(Bus_W), .pending(pending),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          q_rd[$];
  logic [31:0] q_data[$];
  bit          m_pend[NUM_REGS];
  bit          m_wr = 1'b0;
  int          m_rw = 0;
  logic [31:0] m_bus = '0;
  bit          m_alu_acc = 1'b0;
  bit          m_mem_acc = 1'b0;

  // Writes observed by directed tests
  int          wr[$];
  logic [31:0] wd[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit full_b, acc, keep;
    int rd;
    logic [31:0] d;
    if (!rst_n) begin
      q_rd.delete();
      q_data.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_wr = 1'b0; m_rw = 0; m_bus = '0;
      m_alu_acc = 1'b0; m_mem_acc = 1'b0;
      return;
    end
    full_b    = (q_rd.size() == int'(DEPTH));
    m_mem_acc = mem_valid && !full_b;
    m_alu_acc = alu_valid && !mem_valid && !full_b;
    acc  = m_mem_acc || m_alu_acc;
    rd   = mem_valid ? int'(mem_rd) : int'(alu_rd);
    d    = mem_valid ? mem_data : alu_data;
    keep = acc && rd >= 1 && rd < int'(NUM_REGS);
    m_wr = 1'b0;
    if (q_rd.size() > 0 && !wb_stall) begin
      m_wr  = 1'b1;
      m_rw  = q_rd.pop_front();
      m_bus = q_data.pop_front();
      m_pend[m_rw] = 1'b0;
    end
`ifdef WB_BYPASS_EN
    else if (keep && !wb_stall) begin
      m_wr  = 1'b1;
      m_rw  = rd;
      m_bus = d;
      m_pend[rd] = 1'b0;
      keep  = 1'b0;
    end
`endif
    if (keep) begin
      q_rd.push_back(rd);
      q_data.push_back(d);
    end
    if (issue_valid && int'(issue_rd) >= 1 && int'(issue_rd) < int'(NUM_REGS))
      m_pend[issue_rd] = 1'b1;
  endtask

  task automatic compare();
    logic [NUM_REGS-1:0] pv;
    bit f, viol;
    foreach (m_pend[i]) pv[i] = m_pend[i];
    f = (q_rd.size() == int'(DEPTH));
    viol = 1'b0;
    if (issue_valid && int'(issue_rd) >= 1 && int'(issue_rd) < int'(NUM_REGS))
      viol = m_pend[issue_rd];
    chk("issue_contract", viol, 0);
    chk("reg_write", reg_write, m_wr);
    chk("RW", RW, m_rw);
    chk("Bus_W", Bus_W, m_bus);
    chk("pending", pending, pv);
    chk("count", count, q_rd.size());
    chk("full", full, f);
    chk("empty", empty, q_rd.size() == 0);
    chk("mem_ready", mem_ready, !f);
    chk("alu_ready", alu_ready, !f && !mem_valid);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (reg_write) begin
      wr.push_back(int'(RW));
      wd.push_back(Bus_W);
    end
  endtask

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Single ALU write through an empty queue, with scoreboard set/clear
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    chk("t2_pend_set", pending[3], 1);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk("t2_wr", reg_write, 1);
    chk("t2_rw", RW, 3);
    chk("t2_bus", Bus_W, 32'hDEADBEEF);
    chk("t2_pend_clr", pending[3], 0);
    step();
    chk("t2_wr_off", reg_write, 0);
`else
    chk("t2_wr_early", reg_write, 0);
    chk("t2_cnt1", count, 1);
    chk("t2_pend_hold", pending[3], 1);
    step();
    chk("t2_wr", reg_write, 1);
    chk("t2_rw", RW, 3);
    chk("t2_bus", Bus_W, 32'hDEADBEEF);
    chk("t2_pend_clr", pending[3], 0);
    chk("t2_cnt0", count, 0);
    step();
    chk("t2_wr_off", reg_write, 0);
`endif

    // Asynchronous reset mid-cycle with non-zero RW/Bus_W held
    #1 rst_n = 1'b0;
    #1;
    chk("t1_reg_write", reg_write, 0);
    chk("t1_RW", RW, 0);
    chk("t1_Bus_W", Bus_W, 0);
    chk("t1_pending", pending, 0);
    chk("t1_count", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_full", full, 0);
    chk("t1_alu_ready", alu_ready, 1);
    chk("t1_mem_ready", mem_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Load beats ALU; writes in acceptance order
    wr.delete(); wd.delete();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h5;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4;
    #1;
    chk("t3_alu_ready", alu_ready, 0);
    chk("t3_mem_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0;
    step();
    alu_valid = 1'b0;
    repeat (3) step();
    chk("t3_nwr", wr.size(), 2);
    if (wr.size() == 2) begin
      chk("t3_first", wr[0], 5);
      chk("t3_second", wr[1], 4);
    end

    // Fill under stall, then drain in order
    wr.delete(); wd.delete();
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = ADDR_W'(i + 1); alu_data = 32'h10 + 32'(i);
      step();
    end
    alu_valid = 1'b0;
    chk("t4_full", full, 1);
    chk("t4_count", count, 4);
    chk("t4_alu_ready", alu_ready, 0);
    chk("t4_mem_ready", mem_ready, 0);
    chk("t4_nowr", wr.size(), 0);
    wb_stall = 1'b0;
    repeat (6) step();
    chk("t4_nwr", wr.size(), 4);
    for (int i = 0; i < wr.size(); i++) begin
      chk("t4_rd", wr[i], i + 1);
      chk("t4_data", wd[i], 32'h10 + 32'(i));
    end

    // Dropped destinations
    wr.delete(); wd.delete();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1 chk("t5_ready0", alu_ready, 1);
    step();
    alu_rd = 5'd16;
    #1 chk("t5_ready16", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    chk("t5_count", count, 0);
    repeat (3) step();
    chk("t5_nwr", wr.size(), 0);
    chk("t5_empty", empty, 1);

    // Reset while entries are queued under stall
    for (int i = 6; i <= 8; i++) begin
      issue_valid = 1'b1; issue_rd = ADDR_W'(i);
      step();
    end
    issue_valid = 1'b0;
    wb_stall = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      mem_valid = 1'b1; mem_rd = ADDR_W'(i); mem_data = 32'h60 + 32'(i);
      step();
    end
    mem_valid = 1'b0;
    chk("t6_count", count, 3);
    chk("t6_pend", pending, 16'h01C0);
    wr.delete(); wd.delete();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_empty", empty, 1);
    chk("t6_pend_clr", pending, 0);
    chk("t6_count0", count, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wb_stall = 1'b0;
    repeat (5) step();
    chk("t6_nwr", wr.size(), 0);

    // Randomized traffic; producers hold their offer until accepted
    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid || m_alu_acc) begin
        alu_valid = ($urandom_range(0, 99) < 45);
        alu_rd    = ADDR_W'($urandom_range(0, 19));
        alu_data  = $urandom;
      end
      if (!mem_valid || m_mem_acc) begin
        mem_valid = ($urandom_range(0, 99) < 30);
        mem_rd    = ADDR_W'($urandom_range(0, 19));
        mem_data  = $urandom;
      end
      wb_stall = ($urandom_range(0, 99) < 25);
      r = int'($urandom_range(0, 19));
      issue_rd = ADDR_W'(r);
      issue_valid = ($urandom_range(0, 99) < 35);
      if (r >= 1 && r < int'(NUM_REGS) && m_pend[r]) issue_valid = 1'b0;
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0; wb_stall = 1'b0;
    repeat (8) step();
    chk("end_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
